nibble_run_counter: RTL and testbench

- Sequential wrapper that feeds the team's 4-bit incrementer stage and captures its result every cycle.
- Holds a WIDTH-bit count register. The next value comes from NIBBLES chained add_by_one_carry instances:
  - nibble k in1 = count_q[4k+3:4k];
  - nibble 0 cin = 1;
  - nibble k cin = cout of nibble k-1.
- Runs from 0 up to a sampled limit under a start/stop control FSM, then reports completion with a one-cycle done pulse.
- Sits in the datapath sequencer, where it is used for loop and transfer-length counting.

---
 rtl/nibble_run_counter_if.sv | 24 ++
 rtl/nibble_run_counter.sv | 107 ++++++++++
 tb/tb_nibble_run_counter.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/nibble_run_counter_if.sv
// Control and status bundle for nibble_run_counter: run control inputs plus
// the registered count/status outputs.
interface nibble_run_counter_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             stop;
  logic             wrap;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             carry_out;

  modport master (
    output start, stop, wrap, limit,
    input  count, busy, done, carry_out
  );

  modport slave (
    input  start, stop, wrap, limit,
    output count, busy, done, carry_out
  );
endinterface

// File: rtl/nibble_run_counter.sv
// Loop/transfer-length counter built from chained 4-bit incrementer stages,
// run from 0 to a sampled limit under a start/stop FSM with a done pulse.

module add_by_one_carry (
  input  logic [3:0] in1,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  assign {cout, sum} = {1'b0, in1} + {4'b0000, cin};
endmodule

module nibble_run_counter #(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  nibble_run_counter_if.slave     bus
);
  localparam int NIBBLES = WIDTH / 4;

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
      $error("nibble_run_counter: WIDTH must be a positive multiple of 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] limit_q;
  logic             busy_q;
  logic             done_q;

  logic [NIBBLES:0] carry;
  logic [WIDTH-1:0] count_inc;

  // Incrementer runs every cycle; the FSM decides whether its result is taken.
  assign carry[0] = 1'b1;

  generate
    for (genvar k = 0; k < NIBBLES; k++) begin : g_nibble
      add_by_one_carry u_inc (
        .in1  (count_q[4*k +: 4]),
        .cin  (carry[k]),
        .sum  (count_inc[4*k +: 4]),
        .cout (carry[k+1])
      );
    end
  endgenerate

  // Stop outranks the terminal compare so an abort never produces a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      count_q <= '0;
      limit_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            limit_q <= bus.limit;
            count_q <= '0;
            state   <= ST_RUN;
            busy_q  <= 1'b1;
          end else if (state == ST_DONE && bus.stop) begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (bus.stop) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end else if (count_q == limit_q) begin
            done_q <= 1'b1;
            if (bus.wrap) begin
              count_q <= '0;
            end else begin
              state  <= ST_DONE;
              busy_q <= 1'b0;
            end
          end else begin
            count_q <= count_inc;
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.count     = count_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.carry_out = carry[NIBBLES];

endmodule

// File: tb/tb_nibble_run_counter.sv
// Bench for nibble_run_counter: directed scenarios with literal expectations
// plus randomized traffic compared each cycle against a behavioural model.
module tb_nibble_run_counter;
  localparam int WIDTH = 16;
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic clk;
  logic rst_n;

  nibble_run_counter_if #(.WIDTH(WIDTH)) bus ();

  nibble_run_counter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total;
  int bad;

  // Model: only "running or not" matters; IDLE and DONE look identical outside.
  bit m_running;
  int m_count;
  int m_limit;
  bit m_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_running = 1'b0;
      m_count   = 0;
      m_limit   = 0;
      m_done    = 1'b0;
    end else begin
      m_done = 1'b0;
      if (!m_running) begin
        if (bus.start) begin
          m_running = 1'b1;
          m_limit   = int'(bus.limit);
          m_count   = 0;
        end
      end else if (bus.stop) begin
        m_running = 1'b0;
      end else if (m_count == m_limit) begin
        m_done = 1'b1;
        if (bus.wrap) m_count = 0;
        else          m_running = 1'b0;
      end else begin
        m_count = (m_count + 1) % (MAXV + 1);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("model.count", 32'(bus.count), 32'(m_count));
    checkOutput("model.busy", 32'(bus.busy), 32'(m_running));
    checkOutput("model.done", 32'(bus.done), 32'(m_done));
    checkOutput("model.carry_out", 32'(bus.carry_out), 32'(m_count == MAXV));
  end

  task automatic applyStimulus(input bit s, input bit p, input bit w, input logic [WIDTH-1:0] l);
    bus.start = s;
    bus.stop  = p;
    bus.wrap  = w;
    bus.limit = l;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic expectNow(input string tag, input int c, input bit b, input bit d);
    checkOutput({tag, ".count"}, 32'(bus.count), 32'(c));
    checkOutput({tag, ".busy"}, 32'(bus.busy), 32'(b));
    checkOutput({tag, ".done"}, 32'(bus.done), 32'(d));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, '0);
    tick();
    tick();
    expectNow("reset", 0, 0, 0);
    rst_n = 1'b1;

    // Reset mid-run: asynchronous clear without a clock edge.
    applyStimulus(1, 0, 0, 16'd10);
    tick();
    applyStimulus(0, 0, 0, 16'd10);
    repeat (5) tick();
    expectNow("pre_reset", 5, 1, 0);
    #2 rst_n = 1'b0;
    #1 expectNow("async_reset", 0, 0, 0);
    tick();
    rst_n = 1'b1;

    // One-shot, limit 3.
    applyStimulus(1, 0, 0, 16'd3);
    tick();
    applyStimulus(0, 0, 0, 16'd3);
    expectNow("oneshot.e0", 0, 1, 0);
    tick(); expectNow("oneshot.e1", 1, 1, 0);
    tick(); expectNow("oneshot.e2", 2, 1, 0);
    tick(); expectNow("oneshot.e3", 3, 1, 0);
    tick(); expectNow("oneshot.e4", 3, 0, 1);
    tick(); expectNow("oneshot.e5", 3, 0, 0);

    // Wrap, limit 2.
    applyStimulus(1, 0, 1, 16'd2);
    tick();
    applyStimulus(0, 0, 1, 16'd2);
    for (int i = 0; i < 9; i++) begin
      expectNow("wrap", i % 3, 1, (i > 0) && (i % 3 == 0));
      tick();
    end
    applyStimulus(0, 1, 1, 16'd2);
    tick();
    checkOutput("wrap.stop_busy", 32'(bus.busy), 32'd0);
    applyStimulus(0, 0, 0, 16'd2);

    // Stop beats start and the terminal compare.
    applyStimulus(1, 0, 0, 16'd7);
    tick();
    applyStimulus(0, 0, 0, 16'd7);
    repeat (7) tick();
    expectNow("stop.at7", 7, 1, 0);
    applyStimulus(1, 1, 0, 16'd7);
    tick();
    applyStimulus(0, 0, 0, 16'd7);
    expectNow("stop.idle", 7, 0, 0);
    tick(); expectNow("stop.hold", 7, 0, 0);
    applyStimulus(1, 0, 0, 16'd7);
    tick();
    applyStimulus(0, 0, 0, 16'd7);
    expectNow("stop.restart", 0, 1, 0);
    applyStimulus(0, 1, 0, 16'd7);
    tick();
    applyStimulus(0, 0, 0, 16'd7);

    // Full-range run across all nibble carries.
    applyStimulus(1, 0, 0, 16'hFFFF);
    tick();
    applyStimulus(0, 0, 0, 16'hFFFF);
    repeat (4095) tick();
    expectNow("ripple.0fff", 16'h0FFF, 1, 0);
    tick(); expectNow("ripple.1000", 16'h1000, 1, 0);
    repeat (61439) tick();
    expectNow("ripple.ffff", 16'hFFFF, 1, 0);
    checkOutput("ripple.carry_out", 32'(bus.carry_out), 32'd1);
    tick(); expectNow("ripple.done", 16'hFFFF, 0, 1);
    tick(); expectNow("ripple.after", 16'hFFFF, 0, 0);

    // Zero limit, one-shot then wrap.
    applyStimulus(1, 0, 0, 16'd0);
    tick();
    applyStimulus(0, 0, 0, 16'd0);
    expectNow("zero.e0", 0, 1, 0);
    tick(); expectNow("zero.e1", 0, 0, 1);
    applyStimulus(1, 0, 1, 16'd0);
    tick();
    applyStimulus(0, 0, 1, 16'd0);
    expectNow("zerowrap.e0", 0, 1, 0);
    tick(); expectNow("zerowrap.e1", 0, 1, 1);
    tick(); expectNow("zerowrap.e2", 0, 1, 1);
    applyStimulus(0, 1, 0, 16'd0);
    tick();

    // Randomized traffic, model-checked every cycle.
    begin
      bit w;
      w = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(9) == 0) w = ~w;
        applyStimulus($urandom_range(7) == 0, $urandom_range(15) == 0, w,
                      WIDTH'($urandom_range(12)));
        if (i == 1500) begin
          #2 rst_n = 1'b0;
          tick();
          rst_n = 1'b1;
        end else begin
          tick();
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
